// File: rtl/vga_bouncer.sv
// vga_bouncer: pixel-colour stage behind the vga timing generator.
// Draws a black field with a 1-pixel white border and a solid box that
// bounces off the active-area edges. The box moves once per enabled frame
// pulse and changes colour on each bounce. RGB and sync are registered so
// that all outputs stay aligned one clock after hpos/vpos.
module vga_bouncer #(
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX      = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       frame,
    input  logic       enable,
    output logic       hs,
    output logic       vs,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    // Limits and window bounds in 11 bits so sums never wrap.
    localparam logic [10:0] XMAX   = 11'(H_ACTIVE - BOX);
    localparam logic [10:0] YMAX   = 11'(V_ACTIVE - BOX);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] BOX11  = 11'(BOX);
    localparam logic [10:0] HBEG   = 11'(H_START);
    localparam logic [10:0] HEND   = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] VBEG   = 11'(V_START);
    localparam logic [10:0] VEND   = 11'(V_START + V_ACTIVE);
    localparam logic [9:0]  HLAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  VLAST  = 10'(V_ACTIVE - 1);

    typedef enum logic {
        StDec = 1'b0,
        StInc = 1'b1
    } dir_t;

    logic [9:0]  x_q, x_d, y_q, y_d;
    dir_t        dx_q, dx_d, dy_q, dy_d;
    logic [2:0]  idx_q, idx_d;
    logic        bounce_x, bounce_y;
    logic [10:0] x_inc, y_inc;
    logic [9:0]  lx, ly;
    logic        visible, in_box, border;
    logic [11:0] pix_d;

    // Horizontal motion FSM: step or clamp-and-reverse on an enabled frame pulse.
    always_comb begin
        x_d      = x_q;
        dx_d     = dx_q;
        bounce_x = 1'b0;
        x_inc    = {1'b0, x_q} + STEP11;
        if (frame && enable) begin
            unique case (dx_q)
                StInc: begin
                    if (x_inc >= XMAX) begin
                        x_d      = XMAX[9:0];
                        dx_d     = StDec;
                        bounce_x = 1'b1;
                    end else begin
                        x_d = x_inc[9:0];
                    end
                end
                StDec: begin
                    if ({1'b0, x_q} <= STEP11) begin
                        x_d      = '0;
                        dx_d     = StInc;
                        bounce_x = 1'b1;
                    end else begin
                        x_d = x_q - STEP11[9:0];
                    end
                end
            endcase
        end
    end

    // Vertical motion FSM, same rules as the horizontal axis.
    always_comb begin
        y_d      = y_q;
        dy_d     = dy_q;
        bounce_y = 1'b0;
        y_inc    = {1'b0, y_q} + STEP11;
        if (frame && enable) begin
            unique case (dy_q)
                StInc: begin
                    if (y_inc >= YMAX) begin
                        y_d      = YMAX[9:0];
                        dy_d     = StDec;
                        bounce_y = 1'b1;
                    end else begin
                        y_d = y_inc[9:0];
                    end
                end
                StDec: begin
                    if ({1'b0, y_q} <= STEP11) begin
                        y_d      = '0;
                        dy_d     = StInc;
                        bounce_y = 1'b1;
                    end else begin
                        y_d = y_q - STEP11[9:0];
                    end
                end
            endcase
        end
    end

    // Colour index advances once per bounce event (corner counts once), skipping black.
    always_comb begin
        idx_d = idx_q;
        if (bounce_x || bounce_y) begin
            idx_d = (idx_q == 3'd7) ? 3'd1 : idx_q + 3'd1;
        end
    end

    // Pixel colour: outside visible area black, box over border, else black.
    always_comb begin
        lx      = hpos - HBEG[9:0];
        ly      = vpos - VBEG[9:0];
        visible = ({1'b0, hpos} >= HBEG) && ({1'b0, hpos} < HEND) &&
                  ({1'b0, vpos} >= VBEG) && ({1'b0, vpos} < VEND);
        in_box  = ({1'b0, lx} >= {1'b0, x_q}) && ({1'b0, lx} < {1'b0, x_q} + BOX11) &&
                  ({1'b0, ly} >= {1'b0, y_q}) && ({1'b0, ly} < {1'b0, y_q} + BOX11);
        border  = (lx == '0) || (lx == HLAST) || (ly == '0) || (ly == VLAST);
        pix_d   = 12'h000;
        if (visible) begin
            if (in_box) begin
                pix_d = {{4{idx_q[2]}}, {4{idx_q[1]}}, {4{idx_q[0]}}};
            end else if (border) begin
                pix_d = 12'hFFF;
            end
        end
    end

    // Motion state, colour index and aligned output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q   <= '0;
            y_q   <= '0;
            dx_q  <= StInc;
            dy_q  <= StInc;
            idx_q <= 3'd7;
            hs    <= 1'b0;
            vs    <= 1'b0;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            idx_q <= idx_d;
            hs    <= hs_in;
            vs    <= vs_in;
            red   <= pix_d[11:8];
            green <= pix_d[7:4];
            blue  <= pix_d[3:0];
        end
    end

endmodule

// File: tb/tb_vga_bouncer.sv
// Bench for vga_bouncer: a default 640x480 instance and a square 480x480
// instance share stimulus; each is compared against its own behavioural model.
module tb_vga_bouncer;

    logic       clk, reset;
    logic [9:0] hpos, vpos;
    logic       hs_in, vs_in, frame, enable;
    logic       hs0, vs0, hs1, vs1;
    logic [3:0] r0, g0, b0, r1, g1, b1;

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = default, 1 = square 480x480.
    int mx[2], my[2], mdx[2], mdy[2], midx[2];
    int hact[2] = '{640, 480};
    localparam int VACT = 480;
    localparam int BOXS = 32;
    localparam int STP  = 2;

    vga_bouncer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hs_in(hs_in), .vs_in(vs_in),
        .frame(frame), .enable(enable), .hs(hs0), .vs(vs0), .red(r0), .green(g0), .blue(b0)
    );

    vga_bouncer #(.H_ACTIVE(480)) dut_sq (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .hs_in(hs_in), .vs_in(vs_in),
        .frame(frame), .enable(enable), .hs(hs1), .vs(vs1), .red(r1), .green(g1), .blue(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 0; my[k] = 0; mdx[k] = 1; mdy[k] = 1; midx[k] = 7;
        end
    endtask

    // Move one coordinate by +/-STEP, clamping at the limits; returns 1 on a bounce.
    function automatic bit move_axis(inout int p, inout int d, input int lim);
        int np;
        np = p + (d ? STP : -STP);
        move_axis = 1'b0;
        if (np >= lim) begin
            np = lim; d = 0; move_axis = 1'b1;
        end else if (np <= 0) begin
            np = 0; d = 1; move_axis = 1'b1;
        end
        p = np;
    endfunction

    task automatic model_frame();
        for (int k = 0; k < 2; k++) begin
            bit bx, by;
            bx = move_axis(mx[k], mdx[k], hact[k] - BOXS);
            by = move_axis(my[k], mdy[k], VACT - BOXS);
            if (bx || by) midx[k] = (midx[k] == 7) ? 1 : midx[k] + 1;
        end
    endtask

    function automatic logic [11:0] model_pix(input int k, input int hp, input int vp);
        int lx, ly;
        logic [2:0] c;
        lx = hp - 144;
        ly = vp - 35;
        c  = midx[k][2:0];
        if (lx < 0 || lx >= hact[k] || ly < 0 || ly >= VACT) return 12'h000;
        if (lx >= mx[k] && lx < mx[k] + BOXS && ly >= my[k] && ly < my[k] + BOXS)
            return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
        if (lx == 0 || lx == hact[k] - 1 || ly == 0 || ly == VACT - 1) return 12'hFFF;
        return 12'h000;
    endfunction

    // One clock: apply inputs, advance model, check both instances after the edge.
    task automatic drive(input int hp, input int vp, input bit fr, input bit en,
                         input bit hsi, input bit vsi);
        logic [11:0] e0, e1;
        hpos = 10'(hp); vpos = 10'(vp); frame = fr; enable = en; hs_in = hsi; vs_in = vsi;
        e0 = model_pix(0, hp, vp);
        e1 = model_pix(1, hp, vp);
        if (fr && en) model_frame();
        @(posedge clk);
        #1;
        check_eq("rgb", {r0, g0, b0}, e0);
        check_eq("rgb_sq", {r1, g1, b1}, e1);
        check_eq("hs", hs0, hsi);
        check_eq("vs", vs0, vsi);
        check_eq("hs_sq", hs1, hsi);
        check_eq("vs_sq", vs1, vsi);
        frame = 1'b0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b1, 1'b1, 1'($urandom), 1'($urandom));
    endtask

    task automatic probe(input int k);
        int bx, by;
        bx = 144 + mx[k];
        by = 35 + my[k];
        drive(bx, by, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(bx + BOXS - 1, by + BOXS - 1, 1'b0, 1'b1, 1'b1, 1'b0);
        drive(bx - 1, by, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(bx + BOXS, by, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(bx, by + BOXS, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; hpos = '0; vpos = '0; hs_in = 1'b1; vs_in = 1'b1;
        frame = 1'b0; enable = 1'b1;
        model_reset();
        #12;
        check_eq("reset_rgb", {r0, g0, b0}, 12'h000);
        check_eq("reset_hs", hs0, 1'b0);
        check_eq("reset_vs", vs0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Static picture.
        drive(184, 35, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("static_border", {r0, g0, b0}, 12'hFFF);
        drive(244, 135, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("static_black", {r0, g0, b0}, 12'h000);
        drive(150, 40, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("static_box", {r0, g0, b0}, 12'hFFF);
        drive(10, 40, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("static_blank", {r0, g0, b0}, 12'h000);

        // First move to (2,2).
        pulses(1);
        drive(145, 36, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("move_outside", {r0, g0, b0}, 12'h000);
        drive(146, 37, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("move_inside", {r0, g0, b0}, 12'hFFF);

        // 224 pulses: y bounces in default, corner bounce in square instance.
        pulses(223);
        drive(592, 483, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ybounce_blue", {r0, g0, b0}, 12'h00F);
        check_eq("corner_blue", {r1, g1, b1}, 12'h00F);
        drive(591, 483, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("ybounce_left", {r0, g0, b0}, 12'h000);
        pulses(1);
        drive(590, 481, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("corner_once", {r1, g1, b1}, 12'h00F);
        check_eq("after_corner_main", {r0, g0, b0}, 12'h000);

        // 304 pulses: x bounces at 608, idx 2.
        pulses(79);
        drive(752, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("xbounce_green", {r0, g0, b0}, 12'h0F0);
        pulses(1);
        drive(750, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("x606_left", {r0, g0, b0}, 12'h0F0);
        drive(781, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("x606_right", {r0, g0, b0}, 12'h0F0);
        drive(782, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("x606_past", {r0, g0, b0}, 12'h000);

        // enable low: frame pulses ignored.
        for (int i = 0; i < 50; i++) drive(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(750, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("hold_in", {r0, g0, b0}, 12'h0F0);
        drive(749, 323, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("hold_out", {r0, g0, b0}, 12'h000);

        // frame held three cycles: three updates.
        for (int i = 0; i < 3; i++) drive(0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(744, 318, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("held3_in", {r0, g0, b0}, 12'h0F0);
        drive(743, 318, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("held3_out", {r0, g0, b0}, 12'h000);

        // Randomized traffic with periodic probes of both boxes.
        for (int i = 0; i < 1500; i++) begin
            drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom));
            if (i % 50 == 0) begin
                probe(0);
                probe(1);
            end
        end

        // Mid-frame reset with the box at x=100.
        do_reset();
        pulses(50);
        drive(244, 135, 1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("pre_reset_box", {r0, g0, b0}, 12'hFFF);
        hpos = 10'd300;
        reset = 1'b0;
        #1;
        check_eq("midrst_rgb", {r0, g0, b0}, 12'h000);
        check_eq("midrst_hs", hs0, 1'b0);
        check_eq("midrst_vs", vs0, 1'b0);
        check_eq("midrst_rgb_sq", {r1, g1, b1}, 12'h000);
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        drive(144, 35, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("post_rst_box", {r0, g0, b0}, 12'hFFF);
        drive(244, 135, 1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("post_rst_old", {r0, g0, b0}, 12'h000);
        probe(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
